// File: rtl/seq_adder_ctrl.sv
// seq_adder_ctrl: multi-cycle adder controller. A single SLICE_WIDTH-bit adder
// slice is reused once per clock, least significant slice first, to add two
// DATA_WIDTH-bit operands. The result is returned through a start/done handshake.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst    - synchronous, active-high reset
//   start  - request an add; accepted only while idle (busy=0)
//   a, b   - operands, sampled at the accepting edge
//   c_in   - carry into slice 0, sampled at the accepting edge
//   busy   - high from the accepting edge until the result edge
//   done   - one-cycle pulse when sum/c_out/ovf are updated
//   sum    - result register (unsigned add modulo 2^DATA_WIDTH)
//   c_out  - carry out of the most significant slice
//   ovf    - two's-complement overflow
module seq_adder_ctrl #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned SLICE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  c_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  c_out,
    output logic                  ovf
);

    localparam int unsigned NSLICE = DATA_WIDTH / SLICE_WIDTH;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]   op_a, op_a_nxt;
    logic [DATA_WIDTH-1:0]   op_b, op_b_nxt;
    logic [DATA_WIDTH-1:0]   result_reg, result_nxt;
    logic [DATA_WIDTH-1:0]   sum_nxt;
    logic                    carry_reg, carry_nxt;
    logic                    busy_nxt, done_nxt, c_out_nxt, ovf_nxt;

    int unsigned             base;
    logic [SLICE_WIDTH-1:0]  slice_a, slice_b, part;
    logic                    slice_carry;

    // Shared adder slice: selected operand slice plus the held inter-slice carry.
    always_comb begin
        base    = 32'(cnt) * SLICE_WIDTH;
        slice_a = op_a[base +: SLICE_WIDTH];
        slice_b = op_b[base +: SLICE_WIDTH];
        {slice_carry, part} = {1'b0, slice_a} + {1'b0, slice_b}
                            + (SLICE_WIDTH + 1)'(carry_reg);
    end

    // Next-state and next-register values.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_a_nxt   = op_a;
        op_b_nxt   = op_b;
        result_nxt = result_reg;
        carry_nxt  = carry_reg;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        sum_nxt    = sum;
        c_out_nxt  = c_out;
        ovf_nxt    = ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    op_a_nxt  = a;
                    op_b_nxt  = b;
                    carry_nxt = c_in;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                result_nxt[base +: SLICE_WIDTH] = part;
                carry_nxt = slice_carry;
                cnt_nxt   = cnt + CW'(1);
                // Final slice: publish the full result together with both flags.
                if (cnt == CW'(NSLICE - 1)) begin
                    sum_nxt   = result_nxt;
                    c_out_nxt = slice_carry;
                    ovf_nxt   = (op_a[DATA_WIDTH-1] == op_b[DATA_WIDTH-1]) &&
                                (result_nxt[DATA_WIDTH-1] != op_a[DATA_WIDTH-1]);
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any add in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sum        <= '0;
            c_out      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            op_a       <= op_a_nxt;
            op_b       <= op_b_nxt;
            result_reg <= result_nxt;
            carry_reg  <= carry_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            sum        <= sum_nxt;
            c_out      <= c_out_nxt;
            ovf        <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_seq_adder_ctrl.sv
// Directed and random checks of seq_adder_ctrl with slice widths 16, 8 and 64
// sharing one stimulus; each instance has its own outputs and expected latency.
module tb_seq_adder_ctrl;

    logic              clk;
    logic              rst;
    logic              start;
    logic              c_in;
    logic [63:0]       a, b;
    logic [2:0]        busy, done, c_out, ovf;
    logic [2:0][63:0]  sum;

    int n_cmp;
    int n_err;
    int exp_lat [3] = '{4, 8, 1};

    seq_adder_ctrl #(.DATA_WIDTH(64), .SLICE_WIDTH(16)) u_s16 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy[0]), .done(done[0]), .sum(sum[0]), .c_out(c_out[0]), .ovf(ovf[0]));

    seq_adder_ctrl #(.DATA_WIDTH(64), .SLICE_WIDTH(8)) u_s8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy[1]), .done(done[1]), .sum(sum[1]), .c_out(c_out[1]), .ovf(ovf[1]));

    seq_adder_ctrl #(.DATA_WIDTH(64), .SLICE_WIDTH(64)) u_s64 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy[2]), .done(done[2]), .sum(sum[2]), .c_out(c_out[2]), .ovf(ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One add on all three instances; operands are scrambled after acceptance.
    task automatic do_add(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                          input logic tc, input logic [63:0] es, input logic ec, input logic eo);
        int lat [3];
        lat = '{0, 0, 0};
        a = ta; b = tb; c_in = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'($urandom);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (done[i] && lat[i] == 0) lat[i] = cyc;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s u%0d lat", tag, i), 64'(lat[i]), 64'(exp_lat[i]));
            check($sformatf("%s u%0d sum", tag, i), sum[i], es);
            check($sformatf("%s u%0d c_out", tag, i), 64'(c_out[i]), 64'(ec));
            check($sformatf("%s u%0d ovf", tag, i), 64'(ovf[i]), 64'(eo));
        end
    endtask

    initial begin
        int          d1, d2, bc, dc, dl;
        logic [63:0] s1, s2, ra, rb, es;
        logic        rc, ec, eo, seen;

        n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;

        // Reset, then idle with start low.
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle busy", 64'(busy), 64'(0));
            check("idle done", 64'(done), 64'(0));
            check("idle sum", sum[0] | sum[1] | sum[2], 64'(0));
            check("idle c_out", 64'(c_out), 64'(0));
            check("idle ovf", 64'(ovf), 64'(0));
        end

        // Directed vectors, expected values worked out by hand.
        do_add("ripple", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        do_add("wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'h0, 1'b1, 1'b0);
        do_add("posovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        do_add("negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);

        // Start pulsed while busy is ignored.
        a = 64'd100; b = 64'd200; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        bc = busy[0] ? 1 : 0; dc = 0; dl = 0;
        a = 64'd1; b = 64'd1;
        @(posedge clk); #1;
        start = 1'b0;
        bc += busy[0] ? 1 : 0;
        for (int cyc = 2; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            bc += busy[0] ? 1 : 0;
            if (done[0]) begin
                dc++;
                if (dl == 0) dl = cyc;
            end
        end
        check("ignore busy cycles", 64'(bc), 64'(4));
        check("ignore done cycle", 64'(dl), 64'(4));
        check("ignore done count", 64'(dc), 64'(1));
        check("ignore sum", sum[0], 64'd300);

        // Start held high: back-to-back adds.
        a = 64'd3; b = 64'd4; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 64'd10; b = 64'd20;
        d1 = 0; d2 = 0; s1 = '0; s2 = '0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (done[0]) begin
                if (d1 == 0) begin
                    d1 = cyc; s1 = sum[0];
                end else if (d2 == 0) begin
                    d2 = cyc; s2 = sum[0]; start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b first done", 64'(d1), 64'(4));
        check("b2b second done", 64'(d2), 64'(9));
        check("b2b first sum", s1, 64'd7);
        check("b2b second sum", s2, 64'd30);
        repeat (10) @(posedge clk);
        #1;

        // Reset two cycles into RUN aborts the add.
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort sum", sum[0] | sum[1] | sum[2], 64'(0));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen |= |done;
        end
        check("abort no done", 64'(seen), 64'(0));
        do_add("after abort", 64'd5, 64'd6, 1'b0, 64'd11, 1'b0, 1'b0);

        // Random sweep against a 65-bit behavioural add.
        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            {ec, es} = {1'b0, ra} + {1'b0, rb} + 65'(rc);
            eo = (ra[63] == rb[63]) && (es[63] != ra[63]);
            do_add("rand", ra, rb, rc, es, ec, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
